// File: rtl/aes_pkg.sv
// Shared AES-128 decryption definitions: sizes, sequencer state encoding and
// GF(2^8) helpers used by the inverse-round datapath.
package aes_pkg;

  localparam int AES_NR  = 10;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8) as y^254
  // (0 maps to 0 naturally).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] p;
    logic [7:0] r;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    p = y;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round; the last round skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] i_Din,
  input  logic [BLOCK_W-1:0] i_RoundKey,
  input  logic               i_Last,
  output logic [BLOCK_W-1:0] o_Dout
);

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  logic [BLOCK_W-1:0] shifted;
  logic [BLOCK_W-1:0] subbed;
  logic [BLOCK_W-1:0] keyed;
  logic [BLOCK_W-1:0] mixed;

  aes_inv_shift_rows u_inv_shift_rows (
    .i_Din  (i_Din),
    .o_Dout (shifted)
  );

  for (genvar b = 0; b < 16; b++) begin : g_sbox
    assign subbed[BLOCK_W-1-8*b -: 8] = inv_sbox(shifted[BLOCK_W-1-8*b -: 8]);
  end

  assign keyed = subbed ^ i_RoundKey;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mixed[BLOCK_W-1-32*c -: 32] = inv_mix_col(keyed[BLOCK_W-1-32*c -: 32]);
  end

  assign o_Dout = i_Last ? keyed : mixed;

endmodule

// File: rtl/aes_inv_shift_rows.sv
// AES InvShiftRows: row r of the column-major state rotates right by r bytes.
module aes_inv_shift_rows
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] i_Din,
  output logic [BLOCK_W-1:0] o_Dout
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC = r + 4 * ((c - r + 4) % 4);
      localparam int DST = r + 4 * c;
      assign o_Dout[BLOCK_W-1-8*DST -: 8] = i_Din[BLOCK_W-1-8*SRC -: 8];
    end
  end

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES-128 decryption sequencer: one inverse round per clock over a
// shared combinational datapath, round keys fetched from an external table.
module aes_dec_round_ctrl
  import aes_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Start,
  input  logic [BLOCK_W-1:0] i_Din,
  output logic               o_Ready,
  output logic [3:0]         o_KeyRound,
  input  logic [BLOCK_W-1:0] i_RoundKey,
  output logic [BLOCK_W-1:0] o_Dout,
  output logic               o_Valid,
  output state_e             o_FsmState
);

  // Handshake: a block is accepted on any rising edge where i_Start and
  // o_Ready are both high; o_Valid pulses for one cycle when o_Dout holds the
  // plaintext, and o_Dout stays there until the next accept or reset.

  state_e             fsm;
  logic [3:0]         round;
  logic [BLOCK_W-1:0] state_q;
  logic [BLOCK_W-1:0] round_out;
  logic               last;

  assign last = (fsm == FINAL);

  aes_inv_round u_inv_round (
    .i_Din      (state_q),
    .i_RoundKey (i_RoundKey),
    .i_Last     (last),
    .o_Dout     (round_out)
  );

  // IDLE and DONE fetch rk10 so the initial AddRoundKey can happen on accept.
  always_comb begin
    o_KeyRound = 4'(AES_NR);
    case (fsm)
      ROUND:   o_KeyRound = round;
      FINAL:   o_KeyRound = '0;
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      fsm     <= IDLE;
      round   <= '0;
      state_q <= '0;
      o_Valid <= 1'b0;
      o_Ready <= 1'b1;
    end else begin
      o_Valid <= 1'b0;
      case (fsm)
        IDLE, DONE: begin
          if (i_Start) begin
            state_q <= i_Din ^ i_RoundKey;
            round   <= 4'(AES_NR - 1);
            fsm     <= ROUND;
            o_Ready <= 1'b0;
          end else begin
            fsm     <= IDLE;
            o_Ready <= 1'b1;
          end
        end
        ROUND: begin
          state_q <= round_out;
          if (round == 4'd1) begin
            round <= '0;
            fsm   <= FINAL;
          end else begin
            round <= round - 4'd1;
          end
        end
        FINAL: begin
          state_q <= round_out;
          fsm     <= DONE;
          o_Valid <= 1'b1;
          o_Ready <= 1'b1;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign o_Dout     = state_q;
  assign o_FsmState = fsm;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: byte-matrix AES reference model, per-cycle
// compare against a timing model, directed FIPS-197 cases plus random blocks.
module tb_aes_dec_round_ctrl;

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic          i_Clk = 1'b0;
  logic          i_Rst;
  logic          i_Start;
  logic [127:0]  i_Din;
  logic [127:0]  i_RoundKey;
  logic          o_Ready;
  logic [3:0]    o_KeyRound;
  logic [127:0]  o_Dout;
  logic          o_Valid;
  aes_pkg::state_e dbg_state;

  logic [127:0]  rk_tab [0:10];
  logic [7:0]    exp_t [256];
  logic [7:0]    log_t [256];
  logic [7:0]    sbox_t [256];
  logic [7:0]    isbox_t [256];

  int            n_chk = 0;
  int            n_err = 0;
  logic [127:0]  exp_q [$];

  // timing model: age = edges since accept (0 when not busy)
  int            age = 0;
  logic          m_ready = 1'b1;
  logic          m_valid = 1'b0;
  logic [127:0]  m_dout = '0;
  bit            model_live = 1'b0;

  aes_dec_round_ctrl dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Start    (i_Start),
    .i_Din      (i_Din),
    .o_Ready    (o_Ready),
    .o_KeyRound (o_KeyRound),
    .i_RoundKey (i_RoundKey),
    .o_Dout     (o_Dout),
    .o_Valid    (o_Valid),
    .o_FsmState (dbg_state)
  );

  always #5 i_Clk = ~i_Clk;

  assign i_RoundKey = (o_KeyRound <= 4'd10) ? rk_tab[o_KeyRound] : '0;

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
  endfunction

  task automatic build_tables();
    logic [7:0] v;
    logic [7:0] b;
    logic [7:0] s;
    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = v;
      log_t[v] = 8'(i);
      v = v ^ xt(v);
    end
    exp_t[255] = exp_t[0];
    for (int x = 0; x < 256; x++) begin
      b = (x == 0) ? 8'h00 : exp_t[(255 - int'(log_t[x])) % 255];
      s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [7:0]   m [4][4];
    logic [7:0]   a [4];
    logic [7:0]   tmp;
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = ct[127-8*(4*c+r) -: 8] ^ rk_tab[10][127-8*(4*c+r) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 1; r < 4; r++)
        for (int n = 0; n < r; n++) begin
          tmp = m[r][3]; m[r][3] = m[r][2]; m[r][2] = m[r][1]; m[r][1] = m[r][0]; m[r][0] = tmp;
        end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          m[r][c] = isbox_t[m[r][c]] ^ rk_tab[rnd][127-8*(4*c+r) -: 8];
      if (rnd != 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = m[r][c];
          for (int r = 0; r < 4; r++)
            m[r][c] = gm(a[r], 8'h0e) ^ gm(a[(r+1)%4], 8'h0b) ^ gm(a[(r+2)%4], 8'h0d) ^ gm(a[(r+3)%4], 8'h09);
        end
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = m[r][c];
    return res;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(posedge i_Clk) begin
    if (i_Rst) begin
      model_live <= 1'b1;
      age        <= 0;
      m_ready    <= 1'b1;
      m_valid    <= 1'b0;
      m_dout     <= '0;
      exp_q.delete();
    end else if (model_live) begin
      m_valid <= 1'b0;
      if (m_ready && i_Start) begin
        age     <= 1;
        m_ready <= 1'b0;
        exp_q.push_back(ref_decrypt(i_Din));
      end else if (age == 10) begin
        age     <= 0;
        m_valid <= 1'b1;
        m_ready <= 1'b1;
        m_dout  <= exp_q[0];
      end else if (age > 0) begin
        age <= age + 1;
      end
    end
  end

  always @(negedge i_Clk) begin
    if (model_live) begin
      check("ready", 128'(o_Ready), 128'(m_ready));
      check("valid", 128'(o_Valid), 128'(m_valid));
      check("key_round", 128'(o_KeyRound), (age >= 1 && age <= 10) ? 128'(10 - age) : 128'd10);
      if (age == 0) check("dout_idle", o_Dout, m_dout);
      if (o_Valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL scoreboard: o_Valid with dout %h but no block expected", o_Dout);
        end else begin
          check("plaintext", o_Dout, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic count_valids(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (o_Valid) cnt++;
    end
  endtask

  // Accept C.1 from an idle DUT; ends in the DONE cycle.
  task automatic run_c1_directed();
    logic [3:0] tr [11];
    load_key(C1_KEY);
    i_Din   = C1_CT;
    i_Start = 1'b1;
    tr[0]   = o_KeyRound;
    tick();
    i_Start = 1'b0;
    i_Din   = rand128();
    for (int k = 1; k <= 10; k++) begin
      tr[k] = o_KeyRound;
      check("c1_no_early_valid", 128'(o_Valid), 128'd0);
      tick();
    end
    check("c1_valid_at_10", 128'(o_Valid), 128'd1);
    check("c1_plaintext", o_Dout, C1_PT);
    check("c1_ready_in_done", 128'(o_Ready), 128'd1);
    for (int k = 0; k <= 10; k++) check("c1_key_round_trace", 128'(tr[k]), 128'(10 - k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int w;
    logic [127:0] ct2;
    i_Rst   = 1'b1;
    i_Start = 1'b0;
    i_Din   = '0;
    build_tables();
    load_key(C1_KEY);

    // model pins
    check("pin_inv_sbox_63", 128'(isbox_t[8'h63]), 128'h00);
    check("pin_inv_sbox_00", 128'(isbox_t[8'h00]), 128'h52);
    check("pin_rk10", rk_tab[10], C1_RK10);
    check("pin_ref_c1", ref_decrypt(C1_CT), C1_PT);

    tick();
    tick();
    i_Rst = 1'b0;
    check("reset_ready", 128'(o_Ready), 128'd1);
    check("reset_valid", 128'(o_Valid), 128'd0);
    check("reset_dout", o_Dout, 128'd0);
    check("reset_key_round", 128'(o_KeyRound), 128'd10);

    run_c1_directed();

    // hold after completion
    for (int k = 0; k < 20; k++) begin
      tick();
      check("hold_dout", o_Dout, C1_PT);
      check("hold_ready", 128'(o_Ready), 128'd1);
      check("hold_valid", 128'(o_Valid), 128'd0);
    end

    // back-to-back with i_Start held high
    load_key(C1_KEY);
    i_Din   = C1_CT;
    i_Start = 1'b1;
    tick();
    ct2   = rand128();
    i_Din = ct2;
    for (int k = 0; k < 9; k++) tick();
    tick();
    check("b2b_first_valid", 128'(o_Valid), 128'd1);
    check("b2b_first_plain", o_Dout, C1_PT);
    tick();
    i_Start = 1'b0;
    check("b2b_second_accept", 128'(o_Ready), 128'd0);
    for (int k = 0; k < 9; k++) tick();
    check("b2b_second_not_early", 128'(o_Valid), 128'd0);
    tick();
    check("b2b_second_valid", 128'(o_Valid), 128'd1);
    check("b2b_second_plain", o_Dout, ref_decrypt(ct2));
    tick();

    // start while busy is ignored
    i_Din   = C1_CT;
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    tick(); tick(); tick();
    i_Start = 1'b1;
    i_Din   = rand128();
    tick();
    i_Start = 1'b0;
    for (int k = 5; k <= 10; k++) tick();
    check("busy_start_valid", 128'(o_Valid), 128'd1);
    check("busy_start_plain", o_Dout, C1_PT);
    count_valids(12, cnt);
    check("busy_start_single_valid", 128'(cnt), 128'd0);

    // reset mid-operation
    i_Din   = C1_CT;
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0;
    check("midrst_valid", 128'(o_Valid), 128'd0);
    check("midrst_ready", 128'(o_Ready), 128'd1);
    check("midrst_dout", o_Dout, 128'd0);
    count_valids(15, cnt);
    check("midrst_no_valid", 128'(cnt), 128'd0);
    run_c1_directed();
    tick();

    // reset and start on the same edge
    i_Rst   = 1'b1;
    i_Start = 1'b1;
    i_Din   = C1_CT;
    tick();
    i_Rst   = 1'b0;
    i_Start = 1'b0;
    check("rst_start_ready", 128'(o_Ready), 128'd1);
    count_valids(15, cnt);
    check("rst_start_no_valid", 128'(cnt), 128'd0);

    // random blocks, random keys, junk while busy, random gaps
    for (int b = 0; b < 20; b++) begin
      load_key(rand128());
      i_Din   = rand128();
      i_Start = 1'b1;
      tick();
      w = 0;
      while (!o_Valid && w < 13) begin
        i_Din   = rand128();
        i_Start = (w < 8) ? ($urandom_range(0, 3) == 0) : 1'b0;
        tick();
        w++;
      end
      i_Start = 1'b0;
      check("rand_latency", 128'(w), 128'd10);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    i_Start = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    check("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
